// File: rtl/down_timer_pkg.sv
// Shared types and defaults for the down_timer block and its helpers.
package counter_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    RUN    = 2'd2,
    PAUSED = 2'd3
  } timer_state_t;

endpackage : counter_pkg

// File: rtl/down_timer_if.sv
// Load/control/status bundle of the down_timer; master drives the controls, slave is the timer.
interface down_timer_if
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);

  logic             load_valid;
  logic [WIDTH-1:0] load_value;
  logic             load_ready;
  logic             start;
  logic             stop;
  logic             auto_reload;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             tc_pulse;
  logic [WIDTH-1:0] tc_events;

  modport master (
    output load_valid, load_value, start, stop, auto_reload,
    input  load_ready, count, busy, tc_pulse, tc_events
  );

  modport slave (
    input  load_valid, load_value, start, stop, auto_reload,
    output load_ready, count, busy, tc_pulse, tc_events
  );

endinterface : down_timer_if

// File: rtl/down_timer_sat_counter.sv
// Saturating event counter: clear wins over inc, and the value sticks at all-ones.
module sat_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] value
);

  logic [WIDTH-1:0] value_q, value_d;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    value_d = value_q;
    if (clear) begin
      value_d = '0;
    end else if (inc && (value_q != '1)) begin
      value_d = value_q + WIDTH'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule : sat_counter

// File: rtl/down_timer.sv
// Loadable down-counter with run/pause control, optional auto-reload and terminal-count reporting.
module down_timer
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  down_timer_if.slave   bus
);

  timer_state_t     state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;
  logic             load_acc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  end

  // An accepted load overrides start/stop in every state that can take one.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    load_acc = bus.load_valid && (state_q != RUN);

    if (load_acc) begin
      state_d  = ARMED;
      count_d  = bus.load_value;
      reload_d = bus.load_value;
    end else begin
      unique case (state_q)
        IDLE: ;
        ARMED, PAUSED: begin
          if (bus.stop) begin
            state_d = IDLE;
            count_d = '0;
          end else if (bus.start) begin
            state_d = RUN;
          end
        end
        RUN: begin
          if (bus.stop) begin
            state_d = PAUSED;
          end else if (count_q == '0) begin
            tc_d = 1'b1;
            if (bus.auto_reload) begin
              count_d = reload_q;
            end else begin
              state_d = IDLE;
            end
          end else begin
            count_d = count_q - WIDTH'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.busy       = (state_q == RUN);
    bus.load_ready = (state_q != RUN);
    bus.count      = count_q;
    bus.tc_pulse   = tc_q;
  end

  sat_counter #(
    .WIDTH (WIDTH)
  ) u_tc_events (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (load_acc),
    .inc   (tc_d),
    .value (bus.tc_events)
  );

endmodule : down_timer
